// File: rtl/llc_lookup_way_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : llc_lookup_way_pipe_if                                     |
// | Description : Bundle of the lookup-FIFO pop side and the proc-FIFO push  |
// |               side of the LLC way-lookup pipeline.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Parameters : WAYS, WAY_BITS, TAG_BITS, STATE_BITS, ID_BITS               |
// | Modports   : master - the lookup pipe (pops, pushes, drives out_*)       |
// |              slave  - the surrounding FIFOs / environment                |
// | Signals    : fifo_empty_lookup, fifo_pop_lookup, in_tag, in_tags,        |
// |              in_states, in_evict_way, in_id, fifo_full_proc,             |
// |              fifo_push_proc, out_way, out_evict, out_hit, out_all_sd,    |
// |              out_id                                                      |
// +--------------------------------------------------------------------------+

`ifndef LLC_TAG_BITS
`define LLC_TAG_BITS 20
`endif

interface llc_lookup_way_pipe_if #(
  parameter int WAYS       = 16,
  parameter int WAY_BITS   = $clog2(WAYS),
  parameter int TAG_BITS   = `LLC_TAG_BITS,
  parameter int STATE_BITS = 3,
  parameter int ID_BITS    = 4
);
  // Lookup (mem-side) FIFO read port
  logic                                 fifo_empty_lookup;
  logic                                 fifo_pop_lookup;
  logic [TAG_BITS-1:0]                  in_tag;
  logic [WAYS-1:0][TAG_BITS-1:0]        in_tags;
  logic [WAYS-1:0][STATE_BITS-1:0]      in_states;
  logic [WAY_BITS-1:0]                  in_evict_way;
  logic [ID_BITS-1:0]                   in_id;

  // Proc FIFO write port
  logic                                 fifo_full_proc;
  logic                                 fifo_push_proc;
  logic [WAY_BITS-1:0]                  out_way;
  logic                                 out_evict;
  logic                                 out_hit;
  logic                                 out_all_sd;
  logic [ID_BITS-1:0]                   out_id;

  modport master (
    input  fifo_empty_lookup,
    output fifo_pop_lookup,
    input  in_tag,
    input  in_tags,
    input  in_states,
    input  in_evict_way,
    input  in_id,
    input  fifo_full_proc,
    output fifo_push_proc,
    output out_way,
    output out_evict,
    output out_hit,
    output out_all_sd,
    output out_id
  );

  modport slave (
    output fifo_empty_lookup,
    input  fifo_pop_lookup,
    output in_tag,
    output in_tags,
    output in_states,
    output in_evict_way,
    output in_id,
    output fifo_full_proc,
    input  fifo_push_proc,
    input  out_way,
    input  out_evict,
    input  out_hit,
    input  out_all_sd,
    input  out_id
  );
endinterface

`default_nettype wire

// File: rtl/llc_lookup_way_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : llc_lookup_way_pipe                                        |
// | Description : Two-stage LLC way-lookup pipeline. Pops one set-lookup     |
// |               packet per cycle, picks the target way (hit, then empty,   |
// |               then rotating eviction) and pushes the result in order     |
// |               to the proc FIFO under full backpressure.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Optional feature macro : LLC_LOOKUP_STATS_EN                             |
// |   defined   -> adds stat_clr, stat_hits, stat_misses, stat_evicts and    |
// |                parameter CNT_BITS (saturating push statistics)           |
// |   undefined -> no statistics ports or counters                           |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk    in   clock, all flops rising edge                                |
// |   rst    in   asynchronous reset, active low                              |
// |   bus    if   llc_lookup_way_pipe_if.master (pop side + push side)        |
// |   busy   out  any pipeline stage holds a packet                           |
// |   stat_clr / stat_hits / stat_misses / stat_evicts (stats build only)     |
// +--------------------------------------------------------------------------+

`ifndef LLC_TAG_BITS
`define LLC_TAG_BITS 20
`endif
`ifndef INVALID
`define INVALID 3'b000
`endif
`ifndef VALID
`define VALID 3'b001
`endif
`ifndef SD
`define SD 3'b110
`endif

module llc_lookup_way_pipe #(
  parameter int                    WAYS       = 16,
  parameter int                    WAY_BITS   = $clog2(WAYS),
  parameter int                    TAG_BITS   = `LLC_TAG_BITS,
  parameter int                    STATE_BITS = 3,
  parameter logic [STATE_BITS-1:0] ST_INVALID = `INVALID,
  parameter logic [STATE_BITS-1:0] ST_VALID   = `VALID,
  parameter logic [STATE_BITS-1:0] ST_SD      = `SD,
  parameter int                    ID_BITS    = 4
`ifdef LLC_LOOKUP_STATS_EN
  ,
  parameter int                    CNT_BITS   = 32
`endif
) (
  input  logic                clk,
  input  logic                rst,
  llc_lookup_way_pipe_if.master bus,
  output logic                busy
`ifdef LLC_LOOKUP_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [CNT_BITS-1:0] stat_hits,
  output logic [CNT_BITS-1:0] stat_misses,
  output logic [CNT_BITS-1:0] stat_evicts
`endif
);

  // ------------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------------
  logic w_s1_ready;
  logic w_s2_ready;
  logic w_pop;
  logic w_push;

  logic r_s1_valid;
  logic r_s2_valid;

  // S2 can take a new packet if it is empty or its packet leaves this cycle;
  // S1 likewise chains off S2, so a full pipe still accepts while draining.
  assign w_s2_ready = !r_s2_valid || !bus.fifo_full_proc;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;

  // rst gates the pop so the lookup FIFO is never consumed while the
  // pipeline flops are held in reset (they could not capture the packet).
  assign w_pop  = rst && !bus.fifo_empty_lookup && w_s1_ready;
  assign w_push = r_s2_valid && !bus.fifo_full_proc;

  assign bus.fifo_pop_lookup = w_pop;
  assign bus.fifo_push_proc  = w_push;
  assign busy                = r_s1_valid || r_s2_valid;

  // ------------------------------------------------------------------------
  // Stage 1: captured lookup packet
  // ------------------------------------------------------------------------
  logic [TAG_BITS-1:0]             r_s1_tag;
  logic [WAYS-1:0][TAG_BITS-1:0]   r_s1_tags;
  logic [WAYS-1:0][STATE_BITS-1:0] r_s1_states;
  logic [WAY_BITS-1:0]             r_s1_base;
  logic [ID_BITS-1:0]              r_s1_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_tag    <= '0;
      r_s1_tags   <= '0;
      r_s1_states <= '0;
      r_s1_base   <= '0;
      r_s1_id     <= '0;
    end else if (w_s1_ready) begin
      r_s1_valid <= w_pop;
      if (w_pop) begin
        r_s1_tag    <= bus.in_tag;
        r_s1_tags   <= bus.in_tags;
        r_s1_states <= bus.in_states;
        r_s1_base   <= bus.in_evict_way;
        r_s1_id     <= bus.in_id;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Way selection (combinational on the S1 packet)
  // ------------------------------------------------------------------------
  // Each priority class is scanned from the top index down so the last
  // assignment that sticks is the lowest index (or the first position in
  // rotation order for the eviction classes).
  logic                w_hit_found;
  logic [WAY_BITS-1:0] w_hit_way;
  logic                w_inv_found;
  logic [WAY_BITS-1:0] w_inv_way;
  logic                w_val_found;
  logic [WAY_BITS-1:0] w_val_way;
  logic                w_nsd_found;
  logic [WAY_BITS-1:0] w_nsd_way;
  logic [WAY_BITS-1:0] w_rot_idx;

  always_comb begin
    w_hit_found = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_val_found = 1'b0;
    w_val_way   = '0;
    w_nsd_found = 1'b0;
    w_nsd_way   = '0;
    w_rot_idx   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if ((r_s1_tags[i] == r_s1_tag) && (r_s1_states[i] != ST_INVALID)) begin
        w_hit_found = 1'b1;
        w_hit_way   = WAY_BITS'(i);
      end
      if (r_s1_states[i] == ST_INVALID) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_BITS'(i);
      end
      // Rotation position i relative to the eviction base; the add wraps
      // naturally because WAYS is a power of two.
      w_rot_idx = WAY_BITS'(i) + r_s1_base;
      if (r_s1_states[w_rot_idx] == ST_VALID) begin
        w_val_found = 1'b1;
        w_val_way   = w_rot_idx;
      end
      if (r_s1_states[w_rot_idx] != ST_SD) begin
        w_nsd_found = 1'b1;
        w_nsd_way   = w_rot_idx;
      end
    end
  end

  logic [WAY_BITS-1:0] w_sel_way;
  logic                w_sel_evict;
  logic                w_sel_hit;
  logic                w_sel_all_sd;

  always_comb begin
    w_sel_way    = r_s1_base;
    w_sel_evict  = 1'b1;
    w_sel_hit    = 1'b0;
    w_sel_all_sd = 1'b0;
    if (w_hit_found) begin
      w_sel_way   = w_hit_way;
      w_sel_evict = 1'b0;
      w_sel_hit   = 1'b1;
    end else if (w_inv_found) begin
      w_sel_way   = w_inv_way;
      w_sel_evict = 1'b0;
    end else if (w_val_found) begin
      w_sel_way = w_val_way;
    end else if (w_nsd_found) begin
      w_sel_way = w_nsd_way;
    end else begin
      // Every way is SD: report the base way and let the caller stall.
      w_sel_all_sd = 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Stage 2: result registers, held stable while the proc FIFO is full
  // ------------------------------------------------------------------------
  logic [WAY_BITS-1:0] r_out_way;
  logic                r_out_evict;
  logic                r_out_hit;
  logic                r_out_all_sd;
  logic [ID_BITS-1:0]  r_out_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid   <= 1'b0;
      r_out_way    <= '0;
      r_out_evict  <= 1'b0;
      r_out_hit    <= 1'b0;
      r_out_all_sd <= 1'b0;
      r_out_id     <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_way    <= w_sel_way;
        r_out_evict  <= w_sel_evict;
        r_out_hit    <= w_sel_hit;
        r_out_all_sd <= w_sel_all_sd;
        r_out_id     <= r_s1_id;
      end
    end
  end

  assign bus.out_way    = r_out_way;
  assign bus.out_evict  = r_out_evict;
  assign bus.out_hit    = r_out_hit;
  assign bus.out_all_sd = r_out_all_sd;
  assign bus.out_id     = r_out_id;

`ifdef LLC_LOOKUP_STATS_EN
  // ------------------------------------------------------------------------
  // Push statistics: saturating counters, synchronous clear beats a push
  // ------------------------------------------------------------------------
  localparam logic [CNT_BITS-1:0] c_cnt_one = CNT_BITS'(1);

  logic [CNT_BITS-1:0] r_stat_hits;
  logic [CNT_BITS-1:0] r_stat_misses;
  logic [CNT_BITS-1:0] r_stat_evicts;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
      r_stat_evicts <= '0;
    end else if (stat_clr) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
      r_stat_evicts <= '0;
    end else if (w_push) begin
      if (r_out_hit) begin
        if (r_stat_hits != '1) r_stat_hits <= r_stat_hits + c_cnt_one;
      end else begin
        if (r_stat_misses != '1) r_stat_misses <= r_stat_misses + c_cnt_one;
      end
      if (r_out_evict) begin
        if (r_stat_evicts != '1) r_stat_evicts <= r_stat_evicts + c_cnt_one;
      end
    end
  end

  assign stat_hits   = r_stat_hits;
  assign stat_misses = r_stat_misses;
  assign stat_evicts = r_stat_evicts;
`else
  // Statistics build option disabled: no counters, datapath unchanged.
`endif

endmodule

`default_nettype wire
